// File: rtl/hazard_pkg.sv
// Shared types and instruction-field helpers for the hazard scoreboard.
// Latency: none (types/functions only); backpressure: n/a.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  localparam int REG_W   = 5;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  function automatic logic [REG_W-1:0] inst_rd(input logic [31:0] inst);
    return inst[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] inst_rs1(input logic [31:0] inst);
    return inst[RS1_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] inst_rs2(input logic [31:0] inst);
    return inst[RS2_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/pending_slot_table.sv
// Tracks outstanding long-latency destinations; lowest-free allocation and rd match vectors.
// Latency: matches/free tag combinational, slot updates on next edge; backpressure: full flag.
module pending_slot_table
  import hazard_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter int TAG_W       = $clog2(MAX_PENDING)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_en,
  input  logic [REG_W-1:0]       alloc_rd,
  input  logic                   done_en,
  input  logic [TAG_W-1:0]       done_tag,
  input  logic [REG_W-1:0]       rs1,
  input  logic [REG_W-1:0]       rs2,
  output logic [TAG_W-1:0]       free_tag,
  output logic                   full,
  output logic [MAX_PENDING-1:0] rs1_match,
  output logic [MAX_PENDING-1:0] rs2_match,
  output logic [MAX_PENDING-1:0] rd_match
);

  logic [MAX_PENDING-1:0] valid;
  logic [REG_W-1:0]       slot_rd [MAX_PENDING];

  assign full = &valid;

  // Descending scan so the last hit is the lowest free index.
  always_comb begin
    free_tag = '0;
    for (int i = MAX_PENDING - 1; i >= 0; i--) begin
      if (!valid[i]) free_tag = TAG_W'(i);
    end
  end

  always_comb begin
    rs1_match = '0;
    rs2_match = '0;
    rd_match  = '0;
    for (int i = 0; i < MAX_PENDING; i++) begin
      rs1_match[i] = valid[i] && (slot_rd[i] == rs1);
      rs2_match[i] = valid[i] && (slot_rd[i] == rs2);
      rd_match[i]  = valid[i] && (slot_rd[i] == alloc_rd);
    end
  end

  // Allocation picks from pre-clear state, so a slot freed this cycle is never reused here.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (done_en && (32'(done_tag) < MAX_PENDING)) valid[done_tag] <= 1'b0;
      if (alloc_en) begin
        valid[free_tag]   <= 1'b1;
        slot_rd[free_tag] <= alloc_rd;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Operand forwarding, load-use/scoreboard/WAW stall and flush arbitration with a stall counter.
// Latency: all controls combinational, counter/slots update next edge; backpressure: stall holds front end.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter int TAG_W       = $clog2(MAX_PENDING),
  parameter int FWD_WB      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ex_inst,
  input  logic [31:0]      mem_inst,
  input  logic             mem_reg_wr,
  input  logic             mem_mem_read,
  input  logic [31:0]      wb_inst,
  input  logic             wb_reg_wr,
  input  logic             lq_issue,
  output logic [TAG_W-1:0] lq_tag,
  input  logic             lq_done,
  input  logic [TAG_W-1:0] lq_done_tag,
  input  logic             branch_taken,
  input  logic             irq_taken,
  output logic [1:0]       fwd_sel_1,
  output logic [1:0]       fwd_sel_2,
  output logic             stall,
  output logic             flush,
  output logic             pending_full,
  output logic [31:0]      stall_cycles
);

  logic [REG_W-1:0]       ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic [MAX_PENDING-1:0] rs1_match, rs2_match, rd_match;
  logic                   table_full, issue_waw, sb_hit, load_use, stall_raw, alloc_en;
  logic                   mem_fwd_ok, wb_fwd_ok;
  fwd_sel_e               sel1, sel2;
  logic                   unused_inst;

  assign ex_rs1 = inst_rs1(ex_inst);
  assign ex_rs2 = inst_rs2(ex_inst);
  assign mem_rd = inst_rd(mem_inst);
  assign wb_rd  = inst_rd(wb_inst);
  assign unused_inst = ^{ex_inst[31:25], ex_inst[14:0], mem_inst[31:12], mem_inst[6:0],
                         wb_inst[31:12], wb_inst[6:0]};

  pending_slot_table #(
    .MAX_PENDING (MAX_PENDING),
    .TAG_W       (TAG_W)
  ) u_slots (
    .clk       (clk),
    .rst       (rst),
    .alloc_en  (alloc_en),
    .alloc_rd  (mem_rd),
    .done_en   (lq_done && !rst),
    .done_tag  (lq_done_tag),
    .rs1       (ex_rs1),
    .rs2       (ex_rs2),
    .free_tag  (lq_tag),
    .full      (table_full),
    .rs1_match (rs1_match),
    .rs2_match (rs2_match),
    .rd_match  (rd_match)
  );

  // Loads are excluded from memory-stage forwarding: their data is not ready yet.
  assign mem_fwd_ok = mem_reg_wr && !mem_mem_read && (mem_rd != '0);
  assign wb_fwd_ok  = (FWD_WB != 0) && wb_reg_wr && (wb_rd != '0);

  always_comb begin
    sel1 = hazard_pkg::FWD_RF;
    sel2 = hazard_pkg::FWD_RF;
    if (!rst) begin
      if (mem_fwd_ok && mem_rd == ex_rs1)     sel1 = hazard_pkg::FWD_MEM;
      else if (wb_fwd_ok && wb_rd == ex_rs1)  sel1 = hazard_pkg::FWD_WB;
      if (mem_fwd_ok && mem_rd == ex_rs2)     sel2 = hazard_pkg::FWD_MEM;
      else if (wb_fwd_ok && wb_rd == ex_rs2)  sel2 = hazard_pkg::FWD_WB;
    end
  end

  assign fwd_sel_1 = sel1;
  assign fwd_sel_2 = sel2;

  assign issue_waw = (mem_rd != '0) && (|rd_match);
  assign sb_hit    = ((ex_rs1 != '0) && (|rs1_match)) || ((ex_rs2 != '0) && (|rs2_match));
  assign load_use  = mem_mem_read && mem_reg_wr && !lq_issue && (mem_rd != '0) &&
                     ((mem_rd == ex_rs1) || (mem_rd == ex_rs2));
  assign stall_raw = load_use || sb_hit || (lq_issue && (table_full || issue_waw));
  assign alloc_en  = !rst && lq_issue && !table_full && !issue_waw;

  // A redirect squashes the stalled instruction anyway, so flush wins.
  assign flush        = !rst && (branch_taken || irq_taken);
  assign stall        = !rst && !flush && stall_raw;
  assign pending_full = !rst && table_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter MAX_PENDING, default 4: number of outstanding long-latency register writes tracked (load misses, GEMM results); legal range 2..16.
REQ-002 Parameter TAG_W, default $clog2(MAX_PENDING): width of a pending-slot tag.
REQ-003 Parameter FWD_WB, default 1: 1 enables forwarding from the writeback stage; 0 forces writeback-stage hazards onto the register file.
REQ-004 Port list, one clock domain; clock clk and reset rst, with rst synchronous and active-high:
 clk  in  1  clock
 rst  in  1  synchronous active-high reset
 ex_inst  in  32  execute-stage instruction; rs1 = [19:15], rs2 = [24:20]
 mem_inst  in  32  memory-stage instruction; rd = [11:7]
 mem_reg_wr  in  1  memory-stage instruction writes rd
 mem_mem_read  in  1  memory-stage instruction is a load
 wb_inst  in  32  writeback-stage instruction; rd = [11:7]
 wb_reg_wr  in  1  writeback-stage instruction writes rd
 lq_issue  in  1  memory-stage op becomes long-latency; its rd is mem_inst[11:7]
 lq_tag  out  TAG_W  slot allocated to the current lq_issue
 lq_done  in  1  a long-latency result is written this cycle
 lq_done_tag  in  TAG_W  slot being completed
 branch_taken  in  1  redirect from a taken branch
 irq_taken  in  1  interrupt entry
 fwd_sel_1  out  2  rs1 operand source
 fwd_sel_2  out  2  rs2 operand source
 stall  out  1  hold the PC, decode and execute stages
 flush  out  1  squash younger stages
 pending_full  out  1  all slots occupied
 stall_cycles  out  32  saturating count of cycles with stall = 1

Function
REQ-005 Forwarding is combinational; the execute stage uses fwd_sel_x as follows:
 - 0: register file.
 - 1: memory stage, when mem_reg_wr = 1, mem_mem_read = 0, mem rd = rsX and rd != 0.
 - 2: writeback stage, when FWD_WB = 1, wb_reg_wr = 1, wb rd = rsX and rd != 0.
 - Value 3 is never driven.
REQ-006 Forwarding priority: the memory stage beats the writeback stage when both match.
REQ-007 Load-use hazard: stall = 1 when mem_mem_read = 1, mem_reg_wr = 1, lq_issue = 0, and mem rd (nonzero) equals ex rs1 or ex rs2; both sources are checked.
REQ-008 Scoreboard: MAX_PENDING slots, each holding {valid, rd[4:0]}.
REQ-009 Scoreboard stall: stall = 1 while any valid slot's rd (nonzero) equals ex rs1 or ex rs2.
REQ-010 Slot allocation: lq_issue with pending_full = 0 allocates the lowest-index free slot; lq_tag shows that index combinationally in the same cycle; the slot becomes valid on the next clk edge.
REQ-011 Full: lq_issue with pending_full = 1 allocates nothing and asserts stall; the memory stage holds and reissues.
REQ-012 Completion: lq_done clears slot lq_done_tag on the next edge; lq_done to an invalid slot is ignored.
REQ-013 Same-cycle lq_issue and lq_done, free slot available: the completion clears and the allocation takes the lowest free slot as computed before the clear; a slot freed this cycle is not reused until the next cycle.
REQ-014 pending_full = 1 exactly when all slots are valid (registered state).
REQ-015 WAW: stall = 1 when lq_issue targets an rd that already has a valid slot; that issue allocates nothing.
REQ-016 flush = branch_taken | irq_taken, combinational.
REQ-017 Flush and stall together: flush dominates; stall is forced to 0 that cycle.
REQ-018 Flush does not clear the scoreboard; outstanding results still complete.
REQ-019 stall_cycles increments by 1 on each edge where stall = 1 and saturates at 0xFFFF_FFFF.

Reset
REQ-020 When rst = 1 on an edge: all slots become invalid and stall_cycles = 0.
REQ-021 While rst = 1: lq_done and lq_issue are ignored; pending_full = 0, stall = 0, flush = 0, fwd_sel_1 = fwd_sel_2 = 0.
REQ-022 A result outstanding across reset is discarded; a later lq_done for it is ignored.

Structure
REQ-023 Package hazard_pkg holds:
 - enum fwd_sel_e: FWD_RF = 0, FWD_MEM = 1, FWD_WB = 2.
 - Instruction-field slice constants for rd, rs1 and rs2.
REQ-024 One sub-module, pending_slot_table, holds the slot array, lowest-free allocation and the rd match vectors; hazard_scoreboard holds forwarding, stall/flush arbitration and the counter.

Verification
REQ-025 ALU forward: mem_inst add x5, mem_reg_wr = 1; ex_inst reads rs1 = x5, rs2 = x5 -> fwd_sel_1 = 1, fwd_sel_2 = 1, stall = 0.
REQ-026 Priority and x0: mem rd = x7, wb rd = x7, both writing, ex rs2 = x7 -> fwd_sel_2 = 1; repeat with rd = x0 -> fwd_sel_2 = 0.
REQ-027 Load-use on rs2 only: load to x9 in mem, ex rs2 = x9 -> stall = 1; stall_cycles = 1 one cycle later.
REQ-028 Fill and drain, MAX_PENDING = 4: four lq_issue to x1..x4 -> lq_tag 0, 1, 2, 3 and pending_full = 1; fifth issue -> stall = 1, no allocation; lq_done tag 2 -> next issue gets tag 2.
REQ-029 Simultaneous events: full table plus lq_done tag 0 plus lq_issue -> no allocation that cycle; next cycle the issue gets tag 0; branch_taken during a scoreboard stall -> flush = 1, stall = 0.
REQ-030 Reset mid-operation: two slots valid, rst pulse -> pending_full = 0, stall_cycles = 0; a later lq_done tag 1 causes no change.
